cond_logic: RTL

- Conditional-execution stage directly downstream of the ALU in the multicycle ARM-subset datapath.
- Holds the architectural NZCV flag register, which is written from the ALU's ALUFlags.
- Evaluates the 4-bit instruction condition field against the stored flags and latches the result for the instruction in flight.
- Gates the control unit's PC, register-file and memory write requests so that only instructions whose condition passes commit state.

---
 rtl/arm_cond_pkg.sv | 34 +++
 rtl/cond_logic_if.sv | 33 +++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_logic.sv | 52 +++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// Shared types for the ARM-subset conditional-execution stage.
// Condition mnemonics, NZCV bit positions and flag-write encodings.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [1:0] flagw_t;

    localparam flagw_t FLAGW_NZ = 2'b10;
    localparam flagw_t FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_logic_if.sv
// Control-unit <-> cond_logic bundle.
// master: control/ALU side drives requests; slave: cond_logic drives gated enables.
interface cond_logic_if;
    import arm_cond_pkg::*;

    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    flagw_t     FlagW;
    logic       CondLatch;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    modport master (
        output Cond, ALUFlags, FlagW, CondLatch,
        output PCS, NextPC, RegW, MemW, NoWrite,
        input  PCWrite, RegWrite, MemWrite, Flags, CondEx
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, CondLatch,
        input  PCS, NextPC, RegW, MemW, NoWrite,
        output PCWrite, RegWrite, MemWrite, Flags, CondEx
    );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
// Ports: cond (Instr[31:28]), flags {N,Z,C,V} -> cond_pass.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_pass = 1'b1;
        case (cond_e'(cond))
            EQ: cond_pass = z;
            NE: cond_pass = ~z;
            CS: cond_pass = c;
            CC: cond_pass = ~c;
            MI: cond_pass = n;
            PL: cond_pass = ~n;
            VS: cond_pass = v;
            VC: cond_pass = ~v;
            HI: cond_pass = c & ~z;
            LS: cond_pass = ~c | z;
            GE: cond_pass = (n == v);
            LT: cond_pass = (n != v);
            GT: cond_pass = ~z & (n == v);
            LE: cond_pass = z | (n != v);
            AL: cond_pass = 1'b1;
            NV: cond_pass = 1'b1;
            default: cond_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, latched CondEx, write gating.
// Ports: clk, reset_n (async, active low), bus (cond_logic_if.slave).
module cond_logic
    import arm_cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS  = 4'b0000,
    parameter logic       CONDEX_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic       condex_q;
    logic       cond_pass;
    logic       wr_nz;
    logic       wr_cv;

    // Always evaluated against the registered flags, never ALUFlags.
    cond_check u_check (
        .cond      (bus.Cond),
        .flags     (flags_q),
        .cond_pass (cond_pass)
    );

    // Flag writes use the pre-edge CondEx; no forwarding from CondLatch.
    assign wr_nz = |(bus.FlagW & FLAGW_NZ) & condex_q;
    assign wr_cv = |(bus.FlagW & FLAGW_CV) & condex_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= RESET_FLAGS;
            condex_q <= CONDEX_RESET;
        end else begin
            if (bus.CondLatch)
                condex_q <= cond_pass;
            if (wr_nz)
                flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
            if (wr_cv)
                flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
        end
    end

    // Reset also masks NextPC so nothing commits while held in reset.
    assign bus.PCWrite  = reset_n & ((bus.PCS & condex_q) | bus.NextPC);
    assign bus.RegWrite = reset_n & bus.RegW & condex_q & ~bus.NoWrite;
    assign bus.MemWrite = reset_n & bus.MemW & condex_q;
    assign bus.Flags    = flags_q;
    assign bus.CondEx   = condex_q;

endmodule
